// File: rtl/sw_calc_sequencer.sv
// Mode sequencer for the stopwatch/calculator board: keypad FSM, stopwatch command,
// display source arbitration and an iterative double-dabble binary-to-BCD engine.
module sw_calc_sequencer #(
   parameter int unsigned REFRESH_CYCLES = 50000,
   parameter int unsigned CONV_BITS      = 14
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic [31:0] sw_count,
   input  logic [31:0] calc_result,
   input  logic        calc_neg,
   input  logic        calc_done,
   output logic [1:0]  sw_cmd,
   output logic        calc_mode,
   output logic [3:0]  digit3,
   output logic [3:0]  digit2,
   output logic [3:0]  digit1,
   output logic [3:0]  digit0,
   output logic        conv_busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_CALC  = 2'd3;

   localparam logic [1:0] CMD_RUN   = 2'd0;
   localparam logic [1:0] CMD_HOLD  = 2'd1;
   localparam logic [1:0] CMD_CLEAR = 2'd2;

   localparam logic [3:0] DIG_MINUS = 4'd10;
   localparam logic [3:0] DIG_BLANK = 4'd11;

   localparam logic [3:0] KEY_CLEAR  = 4'd10;
   localparam logic [3:0] KEY_PAUSE  = 4'd11;
   localparam logic [3:0] KEY_RESUME = 4'd12;
   localparam logic [3:0] KEY_RUN    = 4'd13;
   localparam logic [3:0] KEY_OP_A   = 4'd14;
   localparam logic [3:0] KEY_OP_B   = 4'd15;

   localparam logic [31:0] MAX_SHOW = 32'd9999;
   localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam int unsigned CW = $clog2(CONV_BITS + 1);

   // One double-dabble iteration: add 3 to every BCD nibble above 4, then shift in the next bit.
   function automatic logic [15:0] dabble_step(input logic [15:0] bcd, input logic in_bit);
      logic [15:0] adj;
      adj = bcd;
      for (int i = 0; i < 4; i++) begin
         if (adj[4*i +: 4] > 4'd4) begin
            adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
         end else begin
            adj[4*i +: 4] = adj[4*i +: 4];
         end
      end
      return {adj[14:0], in_bit};
   endfunction

   logic [1:0]           state_r;
   logic [1:0]           saved_r;
   logic [1:0]           sw_cmd_r;
   logic                 calc_mode_r;
   logic [RW-1:0]        refresh_cnt_r;
   logic                 force_load_r;
   logic                 calc_pending_r;
   logic                 calc_done_d_r;
   logic                 conv_busy_r;
   logic                 neg_r;
   logic [CONV_BITS-1:0] shift_r;
   logic [15:0]          bcd_r;
   logic [CW-1:0]        cnt_r;
   logic [3:0]           digit3_r;
   logic [3:0]           digit2_r;
   logic [3:0]           digit1_r;
   logic [3:0]           digit0_r;

   logic [1:0]           next_state_s;
   logic                 key_op_s;

   // Keypad-driven next-state decode; a state changes only on a key strobe.
   always_comb begin
      next_state_s = state_r;
      key_op_s     = (key_code == KEY_OP_A) || (key_code == KEY_OP_B);
      if (key_valid) begin
         case (state_r)
            ST_IDLE: begin
               if ((key_code == KEY_RUN) || (key_code == KEY_RESUME)) begin
                  next_state_s = ST_RUN;
               end else if (key_op_s) begin
                  next_state_s = ST_CALC;
               end else begin
                  next_state_s = state_r;
               end
            end
            ST_RUN: begin
               if (key_code == KEY_PAUSE) begin
                  next_state_s = ST_PAUSE;
               end else if (key_code == KEY_CLEAR) begin
                  next_state_s = ST_IDLE;
               end else if (key_op_s) begin
                  next_state_s = ST_CALC;
               end else begin
                  next_state_s = state_r;
               end
            end
            ST_PAUSE: begin
               if ((key_code == KEY_RESUME) || (key_code == KEY_RUN)) begin
                  next_state_s = ST_RUN;
               end else if (key_code == KEY_CLEAR) begin
                  next_state_s = ST_IDLE;
               end else if (key_op_s) begin
                  next_state_s = ST_CALC;
               end else begin
                  next_state_s = state_r;
               end
            end
            ST_CALC: begin
               if (key_code == KEY_RUN) begin
                  next_state_s = saved_r;
               end else if (key_code == KEY_CLEAR) begin
                  next_state_s = ST_IDLE;
               end else begin
                  next_state_s = state_r;
               end
            end
            default: next_state_s = ST_IDLE;
         endcase
      end else begin
         next_state_s = state_r;
      end
   end

   logic                 state_change_s;
   logic                 sw_src_s;
   logic                 enter_freeze_s;
   logic                 enter_calc_s;
   logic                 abort_s;
   logic                 calc_blank_s;
   logic                 calc_rise_s;
   logic                 wrap_s;
   logic                 sw_load_s;
   logic                 calc_load_s;
   logic                 load_s;
   logic [31:0]          load_val_s;
   logic                 load_neg_s;
   logic                 load_ovf_s;
   logic [CONV_BITS-1:0] conv_in_s;

   // Load/abort decisions; they follow the post-key state so a same-cycle key picks the source.
   always_comb begin
      state_change_s = (next_state_s != state_r);
      sw_src_s       = (next_state_s != ST_CALC);
      enter_freeze_s = state_change_s && ((next_state_s == ST_IDLE) || (next_state_s == ST_PAUSE));
      enter_calc_s   = state_change_s && (next_state_s == ST_CALC);
      abort_s        = conv_busy_r && state_change_s;
      calc_blank_s   = !sw_src_s && !calc_done;
      calc_rise_s    = calc_done && !calc_done_d_r;
      wrap_s         = (refresh_cnt_r == RW'(REFRESH_CYCLES - 1));
      sw_load_s      = sw_src_s && !conv_busy_r && (wrap_s || force_load_r);
      calc_load_s    = !sw_src_s && (state_r == ST_CALC) && calc_done && !conv_busy_r &&
                       (calc_pending_r || calc_rise_s);
      load_s         = sw_load_s || calc_load_s;
      load_neg_s     = !sw_src_s && calc_neg;
      if (sw_src_s) begin
         load_val_s = sw_count;
      end else begin
         load_val_s = calc_result;
      end
      load_ovf_s = !load_neg_s && (load_val_s > MAX_SHOW);
      // A negative result only shows its two least-significant decimal digits.
      if (load_neg_s) begin
         conv_in_s = CONV_BITS'(calc_result % 32'd100);
      end else begin
         conv_in_s = load_val_s[CONV_BITS-1:0];
      end
   end

   // FSM state, saved stopwatch mode and the registered mode outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         saved_r     <= ST_IDLE;
         sw_cmd_r    <= CMD_CLEAR;
         calc_mode_r <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         calc_mode_r <= (next_state_s == ST_CALC);
         if (enter_calc_s) begin
            saved_r <= state_r;
         end else begin
            saved_r <= saved_r;
         end
         case (next_state_s)
            ST_IDLE:  sw_cmd_r <= CMD_CLEAR;
            ST_RUN:   sw_cmd_r <= CMD_RUN;
            ST_PAUSE: sw_cmd_r <= CMD_HOLD;
            ST_CALC:  sw_cmd_r <= sw_cmd_r;
            default:  sw_cmd_r <= CMD_CLEAR;
         endcase
      end
   end

   // Refresh timer and the pending-load flags for both display sources.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         refresh_cnt_r  <= '0;
         force_load_r   <= 1'b0;
         calc_pending_r <= 1'b0;
         calc_done_d_r  <= 1'b0;
      end else begin
         if (wrap_s) begin
            refresh_cnt_r <= '0;
         end else begin
            refresh_cnt_r <= refresh_cnt_r + RW'(1);
         end
         force_load_r   <= enter_freeze_s || (force_load_r && !sw_load_s);
         calc_pending_r <= enter_calc_s || ((calc_pending_r || calc_rise_s) && !calc_load_s);
         calc_done_d_r  <= calc_done;
      end
   end

   // BCD engine: load, CONV_BITS shifts, then one cycle to publish the digits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conv_busy_r <= 1'b0;
         neg_r       <= 1'b0;
         shift_r     <= '0;
         bcd_r       <= 16'd0;
         cnt_r       <= '0;
         digit3_r    <= DIG_BLANK;
         digit2_r    <= DIG_BLANK;
         digit1_r    <= DIG_BLANK;
         digit0_r    <= DIG_BLANK;
      end else if (calc_blank_s) begin
         conv_busy_r <= 1'b0;
         digit3_r    <= DIG_BLANK;
         digit2_r    <= DIG_BLANK;
         digit1_r    <= DIG_BLANK;
         digit0_r    <= DIG_BLANK;
      end else if (abort_s) begin
         conv_busy_r <= 1'b0;
      end else if (load_s) begin
         if (load_ovf_s) begin
            digit3_r <= DIG_MINUS;
            digit2_r <= DIG_MINUS;
            digit1_r <= DIG_MINUS;
            digit0_r <= DIG_MINUS;
         end else begin
            conv_busy_r <= 1'b1;
            neg_r       <= load_neg_s;
            shift_r     <= conv_in_s;
            bcd_r       <= 16'd0;
            cnt_r       <= '0;
         end
      end else if (conv_busy_r) begin
         if (cnt_r == CW'(CONV_BITS)) begin
            conv_busy_r <= 1'b0;
            if (neg_r) begin
               digit3_r <= DIG_BLANK;
               digit2_r <= DIG_MINUS;
            end else begin
               digit3_r <= bcd_r[15:12];
               digit2_r <= bcd_r[11:8];
            end
            digit1_r <= bcd_r[7:4];
            digit0_r <= bcd_r[3:0];
         end else begin
            bcd_r   <= dabble_step(bcd_r, shift_r[CONV_BITS-1]);
            shift_r <= shift_r << 1;
            cnt_r   <= cnt_r + CW'(1);
         end
      end else begin
         conv_busy_r <= 1'b0;
      end
   end

   assign sw_cmd    = sw_cmd_r;
   assign calc_mode = calc_mode_r;
   assign digit3    = digit3_r;
   assign digit2    = digit2_r;
   assign digit1    = digit1_r;
   assign digit0    = digit0_r;
   assign conv_busy = conv_busy_r;

endmodule

// File: tb/tb_sw_calc_sequencer.sv
// Directed bench for sw_calc_sequencer with a shortened refresh period.
module tb_sw_calc_sequencer;

   localparam int unsigned REFRESH = 40;
   localparam int unsigned CBITS   = 14;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'd0;
   logic [31:0] sw_count = 32'd0;
   logic [31:0] calc_result = 32'd0;
   logic        calc_neg = 1'b0;
   logic        calc_done = 1'b0;
   logic [1:0]  sw_cmd;
   logic        calc_mode;
   logic [3:0]  digit3, digit2, digit1, digit0;
   logic        conv_busy;

   int n_checks = 0;
   int n_fails  = 0;

   sw_calc_sequencer #(.REFRESH_CYCLES(REFRESH), .CONV_BITS(CBITS)) dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
      .sw_count(sw_count), .calc_result(calc_result), .calc_neg(calc_neg),
      .calc_done(calc_done), .sw_cmd(sw_cmd), .calc_mode(calc_mode),
      .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
      .conv_busy(conv_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_digits(input string tag, input logic [3:0] e3, input logic [3:0] e2,
                               input logic [3:0] e1, input logic [3:0] e0);
      check({tag, ".d3"}, {28'd0, digit3}, {28'd0, e3});
      check({tag, ".d2"}, {28'd0, digit2}, {28'd0, e2});
      check({tag, ".d1"}, {28'd0, digit1}, {28'd0, e1});
      check({tag, ".d0"}, {28'd0, digit0}, {28'd0, e0});
   endtask

   task automatic press(input logic [3:0] code);
      key_valid = 1'b1;
      key_code  = code;
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'd0;
   endtask

   task automatic wait_busy(input string tag, input logic level, input int limit);
      int n = 0;
      while (conv_busy !== level && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'd0, conv_busy}, {31'd0, level});
   endtask

   initial begin
      int busy_len;
      int n;
      // 1. reset state and RUN command
      repeat (3) @(negedge clk);
      check("rst.sw_cmd", {30'd0, sw_cmd}, 32'd2);
      check("rst.calc_mode", {31'd0, calc_mode}, 32'd0);
      check("rst.busy", {31'd0, conv_busy}, 32'd0);
      check_digits("rst", 4'd11, 4'd11, 4'd11, 4'd11);
      rst = 1'b0;
      @(negedge clk);
      check("idle.sw_cmd", {30'd0, sw_cmd}, 32'd2);
      press(4'd13);
      check("run.sw_cmd", {30'd0, sw_cmd}, 32'd0);

      // 2. refresh wrap converts 1234 with a 15-cycle busy window
      sw_count = 32'd1234;
      wait_busy("t2.busy_rise", 1'b1, 2 * REFRESH);
      check_digits("t2.hold", 4'd11, 4'd11, 4'd11, 4'd11);
      busy_len = 0;
      while (conv_busy === 1'b1 && busy_len < 40) begin
         busy_len++;
         @(negedge clk);
      end
      check("t2.busy_len", busy_len, 32'd15);
      check_digits("t2.result", 4'd1, 4'd2, 4'd3, 4'd4);

      // 3. pause freezes the latched count, clear shows zeros
      sw_count = 32'd1250;
      press(4'd11);
      check("pause.sw_cmd", {30'd0, sw_cmd}, 32'd1);
      wait_busy("t3.rise", 1'b1, 5);
      wait_busy("t3.fall", 1'b0, 20);
      check_digits("t3.frozen", 4'd1, 4'd2, 4'd5, 4'd0);
      sw_count = 32'd0;
      press(4'd10);
      check("clear.sw_cmd", {30'd0, sw_cmd}, 32'd2);
      wait_busy("t3.clr_rise", 1'b1, 5);
      check("t3.no_flicker", {28'd0, digit2}, 32'd2);
      wait_busy("t3.clr_fall", 1'b0, 20);
      check_digits("t3.zero", 4'd0, 4'd0, 4'd0, 4'd0);

      // 4. calculator negative result
      press(4'd13);
      press(4'd14);
      check("calc.mode", {31'd0, calc_mode}, 32'd1);
      check("calc.sw_cmd", {30'd0, sw_cmd}, 32'd0);
      check_digits("t4.blank", 4'd11, 4'd11, 4'd11, 4'd11);
      calc_result = 32'd57;
      calc_neg    = 1'b1;
      calc_done   = 1'b1;
      wait_busy("t4.rise", 1'b1, 3);
      wait_busy("t4.fall", 1'b0, 20);
      check_digits("t4.neg57", 4'd11, 4'd10, 4'd5, 4'd7);
      press(4'd13);
      check("t4.exit_mode", {31'd0, calc_mode}, 32'd0);
      check("t4.exit_cmd", {30'd0, sw_cmd}, 32'd0);

      // 5. overflow in SW mode, 9999 / overflow / truncated negative in CALC
      sw_count = 32'd12345;
      n = 0;
      while (digit3 !== 4'd10 && n < 3 * REFRESH) begin
         @(negedge clk);
         n++;
      end
      check_digits("t5.sw_ovf", 4'd10, 4'd10, 4'd10, 4'd10);
      check("t5.ovf_busy", {31'd0, conv_busy}, 32'd0);
      calc_result = 32'd9999;
      calc_neg    = 1'b0;
      press(4'd15);
      check("t5.calc_mode", {31'd0, calc_mode}, 32'd1);
      wait_busy("t5.rise", 1'b1, 3);
      wait_busy("t5.fall", 1'b0, 20);
      check_digits("t5.9999", 4'd9, 4'd9, 4'd9, 4'd9);
      calc_done = 1'b0;
      @(negedge clk);
      check_digits("t5.undone", 4'd11, 4'd11, 4'd11, 4'd11);
      calc_result = 32'd10000;
      calc_done   = 1'b1;
      @(negedge clk);
      check_digits("t5.calc_ovf", 4'd10, 4'd10, 4'd10, 4'd10);
      check("t5.calc_ovf_busy", {31'd0, conv_busy}, 32'd0);
      calc_done = 1'b0;
      @(negedge clk);
      calc_result = 32'd12345;
      calc_neg    = 1'b1;
      calc_done   = 1'b1;
      wait_busy("t5.neg_rise", 1'b1, 3);
      wait_busy("t5.neg_fall", 1'b0, 20);
      check_digits("t5.neg45", 4'd11, 4'd10, 4'd4, 4'd5);
      press(4'd13);
      check("t5.back_cmd", {30'd0, sw_cmd}, 32'd0);

      // 6. asynchronous reset in the middle of a conversion
      sw_count = 32'd42;
      wait_busy("t6.rise", 1'b1, 3 * REFRESH);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check("t6.busy", {31'd0, conv_busy}, 32'd0);
      check("t6.sw_cmd", {30'd0, sw_cmd}, 32'd2);
      check_digits("t6", 4'd11, 4'd11, 4'd11, 4'd11);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
